axi_lite_xbar: RTL and testbench

AXI4-Lite 1-to-3 address-decoding router. It sits between the core's arbitrated memory port and three slaves: main memory (s0), UART (s1) and CLINT (s2). It routes each read and write to exactly one slave, keeps one outstanding read and one outstanding write, and answers unmapped addresses with an internal error response.

---
 rtl/axi_xbar_pkg.sv | 27 ++
 rtl/axi_lite_if.sv | 30 +++
 rtl/axi_xbar_decode.sv | 36 +++
 rtl/axi_lite_xbar.sv | 248 ++++++++++++++++++++++++
 tb/tb_axi_lite_xbar.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_xbar_pkg.sv
// rtl/axi_xbar_pkg.sv - shared select, response and FSM state types for the AXI4-Lite router
package axi_xbar_pkg;

    typedef logic [1:0] xbar_sel_t;

    localparam xbar_sel_t SEL_S0  = 2'd0;
    localparam xbar_sel_t SEL_S1  = 2'd1;
    localparam xbar_sel_t SEL_S2  = 2'd2;
    localparam xbar_sel_t SEL_ERR = 2'd3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic {
        R_IDLE,
        R_WAIT
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_ADDR,
        W_DATA,
        W_RESP
    } wr_state_t;

endpackage

// File: rtl/axi_lite_if.sv
// rtl/axi_lite_if.sv - AXI4-Lite bundle with 32-bit address/data, 4-bit wmask, 2-bit resp
interface axi_lite_if;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awvalid, wdata, wmask, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wmask, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_xbar_decode.sv
// rtl/axi_xbar_decode.sv - combinational address-to-slave select decoder
// Ports: i_addr (address to decode), o_sel (SEL_S0/S1/S2, or SEL_ERR on a miss).
// Build option: AXI_LITE_XBAR_DECERR_EN; when undefined a miss selects s2.
module axi_xbar_decode
    import axi_xbar_pkg::*;
#(
    parameter logic [31:0] S0_BASE = 32'h8000_0000,
    parameter logic [31:0] S0_MASK = 32'hF800_0000,
    parameter logic [31:0] S1_BASE = 32'hA000_0000,
    parameter logic [31:0] S1_MASK = 32'hFFFF_F000,
    parameter logic [31:0] S2_BASE = 32'h0200_0000,
    parameter logic [31:0] S2_MASK = 32'hFFFF_0000
)
(
    input  logic [31:0] i_addr,
    output xbar_sel_t   o_sel
);

    // Ordered tests give s0 > s1 > s2 priority on overlapping windows.
    always_comb begin
        if ((i_addr & S0_MASK) == S0_BASE) begin
            o_sel = SEL_S0;
        end else if ((i_addr & S1_MASK) == S1_BASE) begin
            o_sel = SEL_S1;
        end else if ((i_addr & S2_MASK) == S2_BASE) begin
            o_sel = SEL_S2;
        end else begin
`ifdef AXI_LITE_XBAR_DECERR_EN
            o_sel = SEL_ERR;
`else
            o_sel = SEL_S2;
`endif
        end
    end

endmodule

// File: rtl/axi_lite_xbar.sv
// rtl/axi_lite_xbar.sv - AXI4-Lite 1-to-3 address-decoding router, one read and one write in flight
// Ports: clk, reset (asynchronous, active-high); m: upstream master;
//        s0: main memory, s1: UART, s2: CLINT.
// Build option: AXI_LITE_XBAR_DECERR_EN adds an internal responder that answers
//               unmapped addresses with DECERR; otherwise misses route to s2.
module axi_lite_xbar
    import axi_xbar_pkg::*;
#(
    parameter logic [31:0] S0_BASE = 32'h8000_0000,
    parameter logic [31:0] S0_MASK = 32'hF800_0000,
    parameter logic [31:0] S1_BASE = 32'hA000_0000,
    parameter logic [31:0] S1_MASK = 32'hFFFF_F000,
    parameter logic [31:0] S2_BASE = 32'h0200_0000,
    parameter logic [31:0] S2_MASK = 32'hFFFF_0000
)
(
    input  logic      clk,
    input  logic      reset,
    axi_lite_if.slave  m,
    axi_lite_if.master s0,
    axi_lite_if.master s1,
    axi_lite_if.master s2
);

`ifdef AXI_LITE_XBAR_DECERR_EN
    localparam logic DECERR_EN = 1'b1;
`else
    localparam logic DECERR_EN = 1'b0;
`endif

    // The error target always handshakes immediately when the responder exists.
    function automatic logic pick_bit(input logic [2:0] v, input xbar_sel_t sel);
        case (sel)
            SEL_S0:  return v[0];
            SEL_S1:  return v[1];
            SEL_S2:  return v[2];
            default: return DECERR_EN;
        endcase
    endfunction

    function automatic logic [2:0] sel_onehot(input xbar_sel_t sel);
        case (sel)
            SEL_S0:  return 3'b001;
            SEL_S1:  return 3'b010;
            SEL_S2:  return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [31:0] pick_word(input logic [31:0] d0, input logic [31:0] d1,
                                              input logic [31:0] d2, input xbar_sel_t sel);
        case (sel)
            SEL_S0:  return d0;
            SEL_S1:  return d1;
            SEL_S2:  return d2;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [1:0] pick_resp(input logic [1:0] r0, input logic [1:0] r1,
                                             input logic [1:0] r2, input xbar_sel_t sel);
        case (sel)
            SEL_S0:  return r0;
            SEL_S1:  return r1;
            SEL_S2:  return r2;
            default: return RESP_DECERR;
        endcase
    endfunction

    xbar_sel_t w_ar_sel;
    xbar_sel_t w_aw_sel;

    axi_xbar_decode #(
        .S0_BASE(S0_BASE), .S0_MASK(S0_MASK),
        .S1_BASE(S1_BASE), .S1_MASK(S1_MASK),
        .S2_BASE(S2_BASE), .S2_MASK(S2_MASK)
    ) u_ar_decode (
        .i_addr (m.araddr),
        .o_sel  (w_ar_sel)
    );

    axi_xbar_decode #(
        .S0_BASE(S0_BASE), .S0_MASK(S0_MASK),
        .S1_BASE(S1_BASE), .S1_MASK(S1_MASK),
        .S2_BASE(S2_BASE), .S2_MASK(S2_MASK)
    ) u_aw_decode (
        .i_addr (m.awaddr),
        .o_sel  (w_aw_sel)
    );

    logic [2:0] w_s_arready, w_s_rvalid, w_s_awready, w_s_wready, w_s_bvalid;
    logic [2:0] w_s_arvalid, w_s_rready, w_s_awvalid, w_s_wvalid, w_s_bready;

    assign w_s_arready = {s2.arready, s1.arready, s0.arready};
    assign w_s_rvalid  = {s2.rvalid,  s1.rvalid,  s0.rvalid};
    assign w_s_awready = {s2.awready, s1.awready, s0.awready};
    assign w_s_wready  = {s2.wready,  s1.wready,  s0.wready};
    assign w_s_bvalid  = {s2.bvalid,  s1.bvalid,  s0.bvalid};

    // Address and data lines fan out unconditionally; only valids/readies are steered.
    assign s0.araddr = m.araddr;
    assign s1.araddr = m.araddr;
    assign s2.araddr = m.araddr;
    assign s0.awaddr = m.awaddr;
    assign s1.awaddr = m.awaddr;
    assign s2.awaddr = m.awaddr;
    assign s0.wdata  = m.wdata;
    assign s1.wdata  = m.wdata;
    assign s2.wdata  = m.wdata;
    assign s0.wmask  = m.wmask;
    assign s1.wmask  = m.wmask;
    assign s2.wmask  = m.wmask;

    assign {s2.arvalid, s1.arvalid, s0.arvalid} = w_s_arvalid;
    assign {s2.rready,  s1.rready,  s0.rready}  = w_s_rready;
    assign {s2.awvalid, s1.awvalid, s0.awvalid} = w_s_awvalid;
    assign {s2.wvalid,  s1.wvalid,  s0.wvalid}  = w_s_wvalid;
    assign {s2.bready,  s1.bready,  s0.bready}  = w_s_bready;

    // ---------------- read channel ----------------
    rd_state_t   r_rd_state;
    xbar_sel_t   r_rsel;
    logic        w_m_arready, w_m_rvalid;
    logic [31:0] w_m_rdata;
    logic [1:0]  w_m_rresp;

    always_comb begin
        w_s_arvalid = 3'b000;
        w_s_rready  = 3'b000;
        w_m_arready = 1'b0;
        w_m_rvalid  = 1'b0;
        w_m_rdata   = 32'h0;
        w_m_rresp   = RESP_OKAY;
        if (!reset) begin
            case (r_rd_state)
                R_IDLE: begin
                    w_s_arvalid = {3{m.arvalid}} & sel_onehot(w_ar_sel);
                    w_m_arready = pick_bit(w_s_arready, w_ar_sel);
                end
                R_WAIT: begin
                    w_m_rvalid = pick_bit(w_s_rvalid, r_rsel);
                    w_m_rdata  = pick_word(s0.rdata, s1.rdata, s2.rdata, r_rsel);
                    w_m_rresp  = pick_resp(s0.rresp, s1.rresp, s2.rresp, r_rsel);
                    w_s_rready = {3{m.rready}} & sel_onehot(r_rsel);
                end
                default: ;
            endcase
        end
    end

    assign m.arready = w_m_arready;
    assign m.rvalid  = w_m_rvalid;
    assign m.rdata   = w_m_rdata;
    assign m.rresp   = w_m_rresp;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_state <= R_IDLE;
            r_rsel     <= SEL_S0;
        end else begin
            case (r_rd_state)
                R_IDLE: if (m.arvalid && w_m_arready) begin
                    r_rsel     <= w_ar_sel;
                    r_rd_state <= R_WAIT;
                end
                R_WAIT: if (w_m_rvalid && m.rready) begin
                    r_rd_state <= R_IDLE;
                end
                default: r_rd_state <= R_IDLE;
            endcase
        end
    end

    // ---------------- write channel ----------------
    wr_state_t   r_wr_state;
    xbar_sel_t   r_wsel;
    logic        w_m_awready, w_m_wready, w_m_bvalid;
    logic [1:0]  w_m_bresp;
    logic        w_aw_hs, w_w_hs;

    always_comb begin
        w_s_awvalid = 3'b000;
        w_s_wvalid  = 3'b000;
        w_s_bready  = 3'b000;
        w_m_awready = 1'b0;
        w_m_wready  = 1'b0;
        w_m_bvalid  = 1'b0;
        w_m_bresp   = RESP_OKAY;
        if (!reset) begin
            case (r_wr_state)
                W_IDLE: begin
                    // W has no target until an address is presented, so it waits on awvalid.
                    w_s_awvalid = {3{m.awvalid}} & sel_onehot(w_aw_sel);
                    w_s_wvalid  = {3{m.awvalid & m.wvalid}} & sel_onehot(w_aw_sel);
                    w_m_awready = pick_bit(w_s_awready, w_aw_sel);
                    w_m_wready  = m.awvalid & pick_bit(w_s_wready, w_aw_sel);
                end
                W_ADDR: begin
                    w_s_awvalid = {3{m.awvalid}} & sel_onehot(r_wsel);
                    w_m_awready = pick_bit(w_s_awready, r_wsel);
                end
                W_DATA: begin
                    w_s_wvalid = {3{m.wvalid}} & sel_onehot(r_wsel);
                    w_m_wready = pick_bit(w_s_wready, r_wsel);
                end
                W_RESP: begin
                    w_m_bvalid = pick_bit(w_s_bvalid, r_wsel);
                    w_m_bresp  = pick_resp(s0.bresp, s1.bresp, s2.bresp, r_wsel);
                    w_s_bready = {3{m.bready}} & sel_onehot(r_wsel);
                end
                default: ;
            endcase
        end
    end

    assign m.awready = w_m_awready;
    assign m.wready  = w_m_wready;
    assign m.bvalid  = w_m_bvalid;
    assign m.bresp   = w_m_bresp;

    assign w_aw_hs = m.awvalid & w_m_awready;
    assign w_w_hs  = m.wvalid  & w_m_wready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_state <= W_IDLE;
            r_wsel     <= SEL_S0;
        end else begin
            case (r_wr_state)
                W_IDLE: if (w_aw_hs || w_w_hs) begin
                    r_wsel <= w_aw_sel;
                    if (w_aw_hs && w_w_hs) begin
                        r_wr_state <= W_RESP;
                    end else if (w_aw_hs) begin
                        r_wr_state <= W_DATA;
                    end else begin
                        r_wr_state <= W_ADDR;
                    end
                end
                W_ADDR: if (w_aw_hs) r_wr_state <= W_RESP;
                W_DATA: if (w_w_hs)  r_wr_state <= W_RESP;
                W_RESP: if (w_m_bvalid && m.bready) r_wr_state <= W_IDLE;
                default: r_wr_state <= W_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_xbar.sv
// tb/tb_axi_lite_xbar.sv - directed self-checking bench for axi_lite_xbar
module tb_axi_lite_xbar;
    import axi_xbar_pkg::*;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_fail;

    axi_lite_if m_if ();
    axi_lite_if s0_if ();
    axi_lite_if s1_if ();
    axi_lite_if s2_if ();

    axi_lite_xbar dut (
        .clk   (clk),
        .reset (reset),
        .m     (m_if),
        .s0    (s0_if),
        .s1    (s1_if),
        .s2    (s2_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m_if.araddr = '0; m_if.arvalid = 0; m_if.rready = 0;
        m_if.awaddr = '0; m_if.awvalid = 0; m_if.wdata = '0; m_if.wmask = '0;
        m_if.wvalid = 0; m_if.bready = 0;
        s0_if.arready = 0; s0_if.rvalid = 0; s0_if.rdata = '0; s0_if.rresp = '0;
        s0_if.awready = 0; s0_if.wready = 0; s0_if.bvalid = 0; s0_if.bresp = '0;
        s1_if.arready = 0; s1_if.rvalid = 0; s1_if.rdata = '0; s1_if.rresp = '0;
        s1_if.awready = 0; s1_if.wready = 0; s1_if.bvalid = 0; s1_if.bresp = '0;
        s2_if.arready = 0; s2_if.rvalid = 0; s2_if.rdata = '0; s2_if.rresp = '0;
        s2_if.awready = 0; s2_if.wready = 0; s2_if.bvalid = 0; s2_if.bresp = '0;
    endtask

    task automatic test_reset();
        logic [4:0] m_rdy;
        logic [2:0] s_v;
        clear_inputs();
        reset = 1'b1;
        // Requests and slave readies active while in reset must be ignored.
        m_if.araddr = 32'h8000_0000; m_if.arvalid = 1;
        m_if.awaddr = 32'h8000_0000; m_if.awvalid = 1; m_if.wvalid = 1;
        s0_if.arready = 1; s0_if.awready = 1; s0_if.wready = 1; s0_if.rvalid = 1; s0_if.bvalid = 1;
        tick();
        m_rdy = {m_if.arready, m_if.awready, m_if.wready, m_if.rvalid, m_if.bvalid};
        n_cmp++; if (m_rdy !== 5'b0) begin n_fail++; $display("FAIL reset_m_handshakes: got %b want 00000", m_rdy); end
        s_v = {s0_if.arvalid, s0_if.awvalid, s0_if.wvalid};
        n_cmp++; if (s_v !== 3'b0) begin n_fail++; $display("FAIL reset_s0_valids: got %b want 000", s_v); end
        n_cmp++; if (dut.r_rd_state !== R_IDLE) begin n_fail++; $display("FAIL reset_rd_state: got %0d want R_IDLE", dut.r_rd_state); end
        n_cmp++; if (dut.r_wr_state !== W_IDLE) begin n_fail++; $display("FAIL reset_wr_state: got %0d want W_IDLE", dut.r_wr_state); end
        n_cmp++; if (dut.r_rsel !== SEL_S0 || dut.r_wsel !== SEL_S0) begin n_fail++; $display("FAIL reset_sel: got %0d/%0d want 0/0", dut.r_rsel, dut.r_wsel); end
        clear_inputs();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_decode_table();
        logic [31:0] addrs [6];
        logic [2:0]  exp_v [6];
        logic [2:0]  miss_v;
        logic        miss_rdy;
        logic [2:0]  got;
`ifdef AXI_LITE_XBAR_DECERR_EN
        miss_v = 3'b000; miss_rdy = 1'b1;
`else
        miss_v = 3'b100; miss_rdy = 1'b0;
`endif
        addrs[0] = 32'h87FF_FFFC; exp_v[0] = 3'b001;
        addrs[1] = 32'h8800_0000; exp_v[1] = miss_v;
        addrs[2] = 32'hA000_0FFC; exp_v[2] = 3'b010;
        addrs[3] = 32'hA000_1000; exp_v[3] = miss_v;
        addrs[4] = 32'h0200_FFFC; exp_v[4] = 3'b100;
        addrs[5] = 32'h0201_0000; exp_v[5] = miss_v;
        // Slave readies stay low, so no handshake happens; arvalid is dropped before the edge.
        for (int i = 0; i < 6; i++) begin
            m_if.araddr = addrs[i]; m_if.arvalid = 1;
            #1;
            got = {s2_if.arvalid, s1_if.arvalid, s0_if.arvalid};
            n_cmp++; if (got !== exp_v[i]) begin n_fail++; $display("FAIL decode_%h: got %b want %b", addrs[i], got, exp_v[i]); end
            if (exp_v[i] == miss_v) begin
                n_cmp++; if (m_if.arready !== miss_rdy) begin n_fail++; $display("FAIL decode_miss_arready_%h: got %b want %b", addrs[i], m_if.arready, miss_rdy); end
            end
            m_if.arvalid = 0;
            #1;
        end
        tick();
    endtask

    task automatic test_read_s0();
        m_if.araddr = 32'h8000_0010; m_if.arvalid = 1; s0_if.arready = 1;
        #1;
        n_cmp++; if (s0_if.arvalid !== 1'b1) begin n_fail++; $display("FAIL rd_s0_arvalid: got %b want 1", s0_if.arvalid); end
        n_cmp++; if (m_if.arready !== 1'b1) begin n_fail++; $display("FAIL rd_m_arready: got %b want 1", m_if.arready); end
        tick();
        m_if.arvalid = 0; s0_if.arready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if ({m_if.rvalid, s1_if.arvalid, s2_if.arvalid} !== 3'b000) begin n_fail++; $display("FAIL rd_wait_%0d: rvalid/s1/s2 arvalid got %b want 000", i, {m_if.rvalid, s1_if.arvalid, s2_if.arvalid}); end
            tick();
        end
        s0_if.rvalid = 1; s0_if.rdata = 32'hDEAD_BEEF; s0_if.rresp = RESP_OKAY; m_if.rready = 1;
        // Next AR offered during the R handshake must not be taken yet.
        m_if.araddr = 32'h8000_0020; m_if.arvalid = 1; s0_if.arready = 1;
        #1;
        n_cmp++; if (m_if.rvalid !== 1'b1) begin n_fail++; $display("FAIL rd_rvalid: got %b want 1", m_if.rvalid); end
        n_cmp++; if (m_if.rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd_rdata: got %h want deadbeef", m_if.rdata); end
        n_cmp++; if (m_if.rresp !== 2'b00) begin n_fail++; $display("FAIL rd_rresp: got %b want 00", m_if.rresp); end
        n_cmp++; if (s0_if.rready !== 1'b1) begin n_fail++; $display("FAIL rd_s0_rready: got %b want 1", s0_if.rready); end
        n_cmp++; if ({m_if.arready, s0_if.arvalid} !== 2'b00) begin n_fail++; $display("FAIL rd_b2b_blocked: arready/s0.arvalid got %b want 00", {m_if.arready, s0_if.arvalid}); end
        tick();
        s0_if.rvalid = 0; m_if.rready = 0;
        #1;
        n_cmp++; if (m_if.arready !== 1'b1) begin n_fail++; $display("FAIL rd_b2b_next: got %b want 1", m_if.arready); end
        m_if.arvalid = 0; s0_if.arready = 0;
        tick();
    endtask

    task automatic test_write_same_cycle();
        m_if.awaddr = 32'hA000_03F8; m_if.awvalid = 1;
        m_if.wdata = 32'h41; m_if.wmask = 4'b0001; m_if.wvalid = 1;
        s1_if.awready = 1; s1_if.wready = 1;
        #1;
        n_cmp++; if ({s1_if.awvalid, s1_if.wvalid} !== 2'b11) begin n_fail++; $display("FAIL wr_s1_valids: got %b want 11", {s1_if.awvalid, s1_if.wvalid}); end
        n_cmp++; if ({s1_if.wdata, s1_if.wmask} !== {32'h41, 4'b0001}) begin n_fail++; $display("FAIL wr_s1_data: got %h/%b want 41/0001", s1_if.wdata, s1_if.wmask); end
        n_cmp++; if ({s0_if.awvalid, s2_if.awvalid, s0_if.wvalid, s2_if.wvalid} !== 4'b0) begin n_fail++; $display("FAIL wr_others_idle: got %b want 0000", {s0_if.awvalid, s2_if.awvalid, s0_if.wvalid, s2_if.wvalid}); end
        n_cmp++; if ({m_if.awready, m_if.wready} !== 2'b11) begin n_fail++; $display("FAIL wr_m_readies: got %b want 11", {m_if.awready, m_if.wready}); end
        tick();
        m_if.awvalid = 0; m_if.wvalid = 0; s1_if.awready = 0; s1_if.wready = 0;
        n_cmp++; if (dut.r_wr_state !== W_RESP) begin n_fail++; $display("FAIL wr_state_resp: got %0d want W_RESP", dut.r_wr_state); end
        s1_if.bvalid = 1; s1_if.bresp = RESP_OKAY; m_if.bready = 1;
        #1;
        n_cmp++; if ({m_if.bvalid, m_if.bresp, s1_if.bready} !== 4'b1001) begin n_fail++; $display("FAIL wr_bresp: bvalid/bresp/bready got %b want 1001", {m_if.bvalid, m_if.bresp, s1_if.bready}); end
        tick();
        s1_if.bvalid = 0; m_if.bready = 0;
        n_cmp++; if (dut.r_wr_state !== W_IDLE) begin n_fail++; $display("FAIL wr_state_idle: got %0d want W_IDLE", dut.r_wr_state); end
    endtask

    task automatic test_write_aw_first();
        s2_if.awready = 1; s2_if.wready = 1;
        m_if.wvalid = 1; m_if.wdata = 32'h1234_5678; m_if.wmask = 4'hF;
        #1;
        n_cmp++; if ({m_if.wready, s2_if.wvalid} !== 2'b00) begin n_fail++; $display("FAIL awf_w_before_aw: wready/s2.wvalid got %b want 00", {m_if.wready, s2_if.wvalid}); end
        m_if.wvalid = 0;
        m_if.awaddr = 32'h0200_4000; m_if.awvalid = 1;
        #1;
        n_cmp++; if ({m_if.awready, s2_if.awvalid, s2_if.wvalid} !== 3'b110) begin n_fail++; $display("FAIL awf_aw_fwd: got %b want 110", {m_if.awready, s2_if.awvalid, s2_if.wvalid}); end
        tick();
        m_if.awvalid = 0;
        n_cmp++; if (dut.r_wr_state !== W_DATA) begin n_fail++; $display("FAIL awf_state_data: got %0d want W_DATA", dut.r_wr_state); end
        tick();
        m_if.wvalid = 1;
        #1;
        n_cmp++; if ({s2_if.wvalid, m_if.wready, s2_if.awvalid, m_if.awready} !== 4'b1100) begin n_fail++; $display("FAIL awf_w_fwd: got %b want 1100", {s2_if.wvalid, m_if.wready, s2_if.awvalid, m_if.awready}); end
        tick();
        m_if.wvalid = 0; s2_if.awready = 0; s2_if.wready = 0;
        s2_if.bvalid = 1; m_if.bready = 1;
        #1;
        n_cmp++; if (m_if.bvalid !== 1'b1) begin n_fail++; $display("FAIL awf_bvalid: got %b want 1", m_if.bvalid); end
        tick();
        s2_if.bvalid = 0; m_if.bready = 0;
    endtask

    task automatic test_write_w_first();
        m_if.awaddr = 32'h8000_0100; m_if.awvalid = 1; m_if.wvalid = 1;
        s0_if.awready = 0; s0_if.wready = 1;
        #1;
        n_cmp++; if ({m_if.awready, m_if.wready} !== 2'b01) begin n_fail++; $display("FAIL wf_readies: got %b want 01", {m_if.awready, m_if.wready}); end
        tick();
        m_if.wvalid = 0; s0_if.wready = 0;
        n_cmp++; if (dut.r_wr_state !== W_ADDR) begin n_fail++; $display("FAIL wf_state_addr: got %0d want W_ADDR", dut.r_wr_state); end
        s0_if.awready = 1;
        #1;
        n_cmp++; if ({s0_if.awvalid, s0_if.wvalid, m_if.awready} !== 3'b101) begin n_fail++; $display("FAIL wf_aw_fwd: got %b want 101", {s0_if.awvalid, s0_if.wvalid, m_if.awready}); end
        tick();
        m_if.awvalid = 0; s0_if.awready = 0;
        s0_if.bvalid = 1; s0_if.bresp = RESP_OKAY; m_if.bready = 1;
        tick();
        s0_if.bvalid = 0; m_if.bready = 0;
        n_cmp++; if (dut.r_wr_state !== W_IDLE) begin n_fail++; $display("FAIL wf_state_idle: got %0d want W_IDLE", dut.r_wr_state); end
    endtask

    task automatic test_unmapped();
        m_if.araddr = 32'h1000_0000; m_if.arvalid = 1;
`ifdef AXI_LITE_XBAR_DECERR_EN
        #1;
        n_cmp++; if ({m_if.arready, s0_if.arvalid, s1_if.arvalid, s2_if.arvalid} !== 4'b1000) begin n_fail++; $display("FAIL err_ar: got %b want 1000", {m_if.arready, s0_if.arvalid, s1_if.arvalid, s2_if.arvalid}); end
        tick();
        m_if.arvalid = 0; m_if.rready = 1;
        #1;
        n_cmp++; if ({m_if.rvalid, m_if.rresp} !== 3'b111 || m_if.rdata !== 32'h0) begin n_fail++; $display("FAIL err_r: rvalid/rresp got %b rdata %h want 111 / 0", {m_if.rvalid, m_if.rresp}, m_if.rdata); end
        tick();
        m_if.rready = 0;
        m_if.awaddr = 32'h3000_0000; m_if.awvalid = 1; m_if.wvalid = 1;
        #1;
        n_cmp++; if ({m_if.awready, m_if.wready, s2_if.awvalid, s2_if.wvalid} !== 4'b1100) begin n_fail++; $display("FAIL err_aw: got %b want 1100", {m_if.awready, m_if.wready, s2_if.awvalid, s2_if.wvalid}); end
        tick();
        m_if.awvalid = 0; m_if.wvalid = 0; m_if.bready = 1;
        #1;
        n_cmp++; if ({m_if.bvalid, m_if.bresp} !== 3'b111) begin n_fail++; $display("FAIL err_b: got %b want 111", {m_if.bvalid, m_if.bresp}); end
        tick();
        m_if.bready = 0;
`else
        s2_if.arready = 1;
        #1;
        n_cmp++; if ({m_if.arready, s0_if.arvalid, s1_if.arvalid, s2_if.arvalid} !== 4'b1001) begin n_fail++; $display("FAIL dflt_ar: got %b want 1001", {m_if.arready, s0_if.arvalid, s1_if.arvalid, s2_if.arvalid}); end
        tick();
        m_if.arvalid = 0; s2_if.arready = 0;
        s2_if.rvalid = 1; s2_if.rdata = 32'hCAFE_0001; s2_if.rresp = RESP_OKAY; m_if.rready = 1;
        #1;
        n_cmp++; if (m_if.rvalid !== 1'b1 || m_if.rdata !== 32'hCAFE_0001) begin n_fail++; $display("FAIL dflt_r: rvalid %b rdata %h want 1 cafe0001", m_if.rvalid, m_if.rdata); end
        tick();
        s2_if.rvalid = 0; m_if.rready = 0;
`endif
    endtask

    task automatic test_concurrent();
        m_if.araddr = 32'h8000_0040; m_if.arvalid = 1; s0_if.arready = 1;
        tick();
        m_if.arvalid = 0; s0_if.arready = 0;
        m_if.awaddr = 32'hA000_0004; m_if.awvalid = 1; m_if.wvalid = 1;
        m_if.wdata = 32'h55; m_if.wmask = 4'h1;
        s1_if.awready = 1; s1_if.wready = 1;
        #1;
        n_cmp++; if ({m_if.awready, m_if.wready, m_if.rvalid} !== 3'b110) begin n_fail++; $display("FAIL cc_write_accept: got %b want 110", {m_if.awready, m_if.wready, m_if.rvalid}); end
        tick();
        m_if.awvalid = 0; m_if.wvalid = 0; s1_if.awready = 0; s1_if.wready = 0;
        s1_if.bvalid = 1; s1_if.bresp = RESP_SLVERR; m_if.bready = 1;
        #1;
        n_cmp++; if ({m_if.bvalid, m_if.bresp, m_if.rvalid} !== 4'b1100) begin n_fail++; $display("FAIL cc_write_resp: bvalid/bresp/rvalid got %b want 1100", {m_if.bvalid, m_if.bresp, m_if.rvalid}); end
        tick();
        s1_if.bvalid = 0; m_if.bready = 0;
        for (int i = 0; i < 3; i++) tick();
        n_cmp++; if (dut.r_rd_state !== R_WAIT) begin n_fail++; $display("FAIL cc_read_pending: got %0d want R_WAIT", dut.r_rd_state); end
        s0_if.rvalid = 1; s0_if.rdata = 32'h1111_2222; s0_if.rresp = RESP_OKAY; m_if.rready = 1;
        #1;
        n_cmp++; if (m_if.rvalid !== 1'b1 || m_if.rdata !== 32'h1111_2222) begin n_fail++; $display("FAIL cc_read_done: rvalid %b rdata %h want 1 11112222", m_if.rvalid, m_if.rdata); end
        tick();
        s0_if.rvalid = 0; m_if.rready = 0;
    endtask

    task automatic test_reset_mid_read();
        m_if.araddr = 32'h8000_0080; m_if.arvalid = 1; s0_if.arready = 1;
        tick();
        m_if.arvalid = 0; s0_if.arready = 0;
        #1;
        reset = 1'b1;
        #1;
        n_cmp++; if (dut.r_rd_state !== R_IDLE) begin n_fail++; $display("FAIL rst_mid_state: got %0d want R_IDLE", dut.r_rd_state); end
        s0_if.rvalid = 1; s0_if.rdata = 32'hBAD0_BAD0; m_if.rready = 1;
        #1;
        n_cmp++; if ({m_if.rvalid, s0_if.rready} !== 2'b00) begin n_fail++; $display("FAIL rst_mid_drop: rvalid/s0.rready got %b want 00", {m_if.rvalid, s0_if.rready}); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        n_cmp++; if ({m_if.rvalid, s0_if.rready} !== 2'b00) begin n_fail++; $display("FAIL rst_late_rvalid: got %b want 00", {m_if.rvalid, s0_if.rready}); end
        tick();
        clear_inputs();
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        reset  = 1'b1;
        test_reset();
        test_decode_table();
        test_read_s0();
        test_write_same_cycle();
        test_write_aw_first();
        test_write_w_first();
        test_unmapped();
        test_concurrent();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
